// File: rtl/div_share_ctrl_pkg.sv
// Shared types and defaults for the divider-sharing controller.
package div_ctrl_pkg;

   localparam int DIV_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } ctrl_state_t;

   typedef struct packed {
      logic div_by_zero;
      logic timeout;
   } rsp_flags_t;

endpackage

// File: rtl/div_share_ctrl_if.sv
// Request, response and divider-side signals of the shared-divider controller.
// The slave modport is the controller's view; master is the surrounding system.
interface div_share_ctrl_if
   import div_ctrl_pkg::*;
#(
   parameter int P_WIDTH   = DIV_WIDTH,
   parameter int P_NUM_REQ = 4
);
   localparam int ID_W = $clog2(P_NUM_REQ);

   logic [P_NUM_REQ-1:0]         req_valid;
   logic [P_NUM_REQ-1:0]         req_ready;
   logic [P_NUM_REQ*P_WIDTH-1:0] req_dividend;
   logic [P_NUM_REQ*P_WIDTH-1:0] req_divisor;

   logic                         rsp_valid;
   logic                         rsp_ready;
   logic [ID_W-1:0]              rsp_id;
   logic [P_WIDTH-1:0]           rsp_quotient;
   logic [P_WIDTH-1:0]           rsp_remainder;
   logic                         rsp_div_by_zero;
   logic                         rsp_timeout;

   logic                         div_start;
   logic [P_WIDTH-1:0]           div_dividend;
   logic [P_WIDTH-1:0]           div_divisor;
   logic                         div_done;
   logic [P_WIDTH-1:0]           div_quotient;
   logic [P_WIDTH-1:0]           div_remainder;

   modport slave (
      input  req_valid, req_dividend, req_divisor, rsp_ready,
             div_done, div_quotient, div_remainder,
      output req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder,
             rsp_div_by_zero, rsp_timeout, div_start, div_dividend, div_divisor
   );

   modport master (
      output req_valid, req_dividend, req_divisor, rsp_ready,
             div_done, div_quotient, div_remainder,
      input  req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder,
             rsp_div_by_zero, rsp_timeout, div_start, div_dividend, div_divisor
   );

endinterface

// File: rtl/div_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// after ptr_i, wrapping to 0. The pointer register lives in the caller.
module rr_arbiter #(
   parameter  int P_NUM_REQ = 4,
   localparam int ID_W      = $clog2(P_NUM_REQ)
) (
   input  logic [P_NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]      ptr_i,
   input  logic                 en_i,
   output logic [P_NUM_REQ-1:0] grant_o,
   output logic [ID_W-1:0]      idx_o
);

   logic [ID_W-1:0] cand;
   logic            found;

   // Scan from the pointer upward and take the first valid requester.
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      cand    = '0;
      if (en_i) begin
         for (int k = 0; k < P_NUM_REQ; k++) begin
            cand = ID_W'((int'(ptr_i) + k) % P_NUM_REQ);
            if (!found && req_i[cand]) begin
               found         = 1'b1;
               grant_o[cand] = 1'b1;
               idx_o         = cand;
            end
         end
      end
   end

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one divider among several requesters: round-robin grant, operand
// latch, start pulse, done wait with watchdog, valid/ready response.
//
// state | meaning
// IDLE  | arbitrate; req_ready follows the round-robin winner
// ISSUE | one-cycle div_start, watchdog cleared
// WAIT  | wait for div_done or watchdog expiry
// RESP  | hold response until rsp_ready
module div_share_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int P_WIDTH   = DIV_WIDTH,
   parameter int P_NUM_REQ = 4,
   parameter int P_TIMEOUT = 64
) (
   input logic             clk,
   input logic             rst,
   div_share_ctrl_if.slave bus
);

   localparam int              ID_W    = $clog2(P_NUM_REQ);
   localparam int              WD_W    = $clog2(P_TIMEOUT);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(P_TIMEOUT - 1);
   localparam logic [ID_W-1:0] ID_LAST = ID_W'(P_NUM_REQ - 1);

   ctrl_state_t          state_q, state_d;
   logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]      id_q, id_d;
   logic [P_WIDTH-1:0]   dvd_q, dvd_d;
   logic [P_WIDTH-1:0]   dvs_q, dvs_d;
   logic [P_WIDTH-1:0]   quo_q, quo_d;
   logic [P_WIDTH-1:0]   rem_q, rem_d;
   logic [WD_W-1:0]      wd_q, wd_d;
   rsp_flags_t           flags_q, flags_d;

   logic                 arb_en;
   logic [P_NUM_REQ-1:0] grant;
   logic [ID_W-1:0]      grant_idx;
   logic [P_WIDTH-1:0]   dvd_sel, dvs_sel;

   // No grant while reset is asserted so req_ready reads 0 during reset.
   assign arb_en = (state_q == ST_IDLE) && !rst;

   rr_arbiter #(.P_NUM_REQ(P_NUM_REQ)) u_arb (
      .req_i   (bus.req_valid),
      .ptr_i   (rr_ptr_q),
      .en_i    (arb_en),
      .grant_o (grant),
      .idx_o   (grant_idx)
   );

   // Operand mux for the granted requester (grant is one-hot or zero).
   always_comb begin
      dvd_sel = '0;
      dvs_sel = '0;
      for (int i = 0; i < P_NUM_REQ; i++) begin
         if (grant[i]) begin
            dvd_sel = bus.req_dividend[i*P_WIDTH +: P_WIDTH];
            dvs_sel = bus.req_divisor[i*P_WIDTH +: P_WIDTH];
         end
      end
   end

   // Next-state and datapath next values; everything holds by default.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      id_d     = id_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      quo_d    = quo_q;
      rem_d    = rem_q;
      wd_d     = wd_q;
      flags_d  = flags_q;
      case (state_q)
         ST_IDLE: begin
            if (|grant) begin
               id_d     = grant_idx;
               dvd_d    = dvd_sel;
               dvs_d    = dvs_sel;
               rr_ptr_d = (grant_idx == ID_LAST) ? '0 : grant_idx + 1'b1;
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            wd_d    = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (bus.div_done) begin
               quo_d               = bus.div_quotient;
               rem_d               = bus.div_remainder;
               flags_d.div_by_zero = (dvs_q == '0);
               flags_d.timeout     = 1'b0;
               state_d             = ST_RESP;
            end else if (wd_q == WD_LAST) begin
               quo_d               = '0;
               rem_d               = '0;
               flags_d.div_by_zero = 1'b0;
               flags_d.timeout     = 1'b1;
               state_d             = ST_RESP;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, pointer, operand and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         id_q     <= '0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         quo_q    <= '0;
         rem_q    <= '0;
         wd_q     <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         id_q     <= id_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         quo_q    <= quo_d;
         rem_q    <= rem_d;
         wd_q     <= wd_d;
         flags_q  <= flags_d;
      end
   end

   assign bus.req_ready       = grant;
   assign bus.div_start       = (state_q == ST_ISSUE);
   assign bus.div_dividend    = dvd_q;
   assign bus.div_divisor     = dvs_q;
   assign bus.rsp_valid       = (state_q == ST_RESP);
   assign bus.rsp_id          = id_q;
   assign bus.rsp_quotient    = quo_q;
   assign bus.rsp_remainder   = rem_q;
   assign bus.rsp_div_by_zero = flags_q.div_by_zero;
   assign bus.rsp_timeout     = flags_q.timeout;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Bench for div_share_ctrl with a behavioural divider (36-cycle normal,
// 2-cycle divide-by-zero latency, optional never-done stub).
module tb_div_share_ctrl;

   localparam int W  = 32;
   localparam int N  = 4;
   localparam int TO = 64;

   logic clk;
   logic rst;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   onehot_viol = 0;
   logic stub  = 1'b0;
   logic stray = 1'b0;

   div_share_ctrl_if #(.P_WIDTH(W), .P_NUM_REQ(N)) bus ();

   div_share_ctrl #(.P_WIDTH(W), .P_NUM_REQ(N), .P_TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // behavioural divider
   int          dcnt;
   logic [W-1:0] dq, dr;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         dcnt <= 0;
         dq   <= '0;
         dr   <= '0;
      end else if (bus.div_start && !stub) begin
         if (bus.div_divisor == '0) begin
            dcnt <= 2;
            dq   <= '1;
            dr   <= bus.div_dividend;
         end else begin
            dcnt <= W + 4;
            dq   <= bus.div_dividend / bus.div_divisor;
            dr   <= bus.div_dividend % bus.div_divisor;
         end
      end else if (dcnt != 0) begin
         dcnt <= dcnt - 1;
      end
   end
   assign bus.div_done      = (dcnt == 1) || stray;
   assign bus.div_quotient  = dq;
   assign bus.div_remainder = dr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // scoreboard
   typedef struct {
      int          id;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic        dbz;
      logic        to;
   } exp_t;
   exp_t sb[$];
   int   rsp_log[$];
   int   mptr = 0;

   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (rst) begin
            sb.delete();
            mptr = 0;
         end else begin
            if ($countones(bus.req_ready) > 1) onehot_viol++;
            if (bus.req_ready != '0) begin
               int           eg;
               int           c;
               logic [W-1:0] a, b;
               exp_t         e;
               eg = -1;
               for (int k = 0; k < N; k++) begin
                  c = (mptr + k) % N;
                  if (eg < 0 && bus.req_valid[c]) eg = c;
               end
               chk("grant", 64'(bus.req_ready), (eg < 0) ? 64'd0 : (64'd1 << eg));
               if (eg >= 0) begin
                  a = bus.req_dividend[eg*W +: W];
                  b = bus.req_divisor[eg*W +: W];
                  e.id = eg;
                  if (stub) begin
                     e.q = '0; e.r = '0; e.dbz = 1'b0; e.to = 1'b1;
                  end else if (b == '0) begin
                     e.q = '1; e.r = a; e.dbz = 1'b1; e.to = 1'b0;
                  end else begin
                     e.q = a / b; e.r = a % b; e.dbz = 1'b0; e.to = 1'b0;
                  end
                  sb.push_back(e);
                  mptr = (eg + 1) % N;
               end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
               if (sb.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL sb_unexpected: response id %0d with nothing outstanding", bus.rsp_id);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  rsp_log.push_back(int'(bus.rsp_id));
                  chk("sb_id", 64'(bus.rsp_id), 64'(e.id));
                  chk("sb_quotient", 64'(bus.rsp_quotient), 64'(e.q));
                  chk("sb_remainder", 64'(bus.rsp_remainder), 64'(e.r));
                  chk("sb_flags", {62'd0, bus.rsp_div_by_zero, bus.rsp_timeout}, {62'd0, e.dbz, e.to});
               end
            end
         end
      end
   end

   task automatic wait_rsp(output int t_seen);
      int g;
      g = 0;
      while (!bus.rsp_valid && g < 300) begin
         step();
         g++;
      end
      if (!bus.rsp_valid) begin
         n_tests++;
         n_fail++;
         $display("FAIL rsp_wait: rsp_valid absent after %0d cycles", g);
      end
      t_seen = cyc;
   endtask

   typedef struct {
      int          id;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] eq;
      logic [W-1:0] er;
      logic        dbz;
      int          lat;
   } vec_t;
   vec_t vecs[5];
   int   exp_order[5];

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end

   initial begin
      int           t0, tr, bad;
      int           sid;
      logic [W-1:0] sq, sr;
      logic [1:0]   sf;

      vecs[0] = '{2, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 38};
      vecs[1] = '{1, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4};
      vecs[2] = '{3, 32'd12345, 32'd1, 32'd12345, 32'd0, 1'b0, 38};
      vecs[3] = '{0, 32'd7, 32'd100, 32'd0, 32'd7, 1'b0, 38};
      vecs[4] = '{2, 32'hDEAD_BEEF, 32'h10, 32'h0DEA_DBEE, 32'hF, 1'b0, 38};
      exp_order = '{0, 1, 2, 3, 0};

      rst = 1'b1;
      bus.req_valid    = '0;
      bus.req_dividend = '0;
      bus.req_divisor  = '0;
      bus.rsp_ready    = 1'b1;
      repeat (3) step();

      // reset values, with requests pending to show req_ready stays low
      bus.req_valid = 4'hF;
      #1;
      chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_div_start", 64'(bus.div_start), 64'd0);
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
      chk("rst_rsp_q_r", {bus.rsp_quotient, bus.rsp_remainder}, 64'd0);
      chk("rst_flags", {62'd0, bus.rsp_div_by_zero, bus.rsp_timeout}, 64'd0);
      chk("rst_div_ops", {bus.div_dividend, bus.div_divisor}, 64'd0);
      bus.req_valid = '0;
      step();
      rst = 1'b0;
      step();

      // all four requesters continuously valid
      for (int i = 0; i < N; i++) begin
         bus.req_dividend[i*W +: W] = 32'(1000 * (i + 1) + 37 * i);
         bus.req_divisor[i*W +: W]  = 32'(i + 3);
      end
      bus.req_valid = 4'hF;
      tr = 0;
      while (rsp_log.size() < 5 && tr < 400) begin
         step();
         tr++;
      end
      bus.req_valid = '0;
      for (int k = 0; k < 5; k++)
         chk("rr_order", 64'((k < rsp_log.size()) ? rsp_log[k] : -1), 64'(exp_order[k]));
      step();

      // table of single requests
      for (int v = 0; v < 5; v++) begin
         bus.req_dividend[vecs[v].id*W +: W] = vecs[v].a;
         bus.req_divisor[vecs[v].id*W +: W]  = vecs[v].b;
         bus.req_valid = 4'(1 << vecs[v].id);
         t0 = cyc;
         #1;
         chk("tbl_req_ready", 64'(bus.req_ready), 64'd1 << vecs[v].id);
         step();
         bus.req_valid = '0;
         chk("tbl_div_start", 64'(bus.div_start), 64'd1);
         wait_rsp(tr);
         chk("tbl_latency", 64'(tr - t0), 64'(vecs[v].lat));
         chk("tbl_id", 64'(bus.rsp_id), 64'(vecs[v].id));
         chk("tbl_quotient", 64'(bus.rsp_quotient), 64'(vecs[v].eq));
         chk("tbl_remainder", 64'(bus.rsp_remainder), 64'(vecs[v].er));
         chk("tbl_flags", {62'd0, bus.rsp_div_by_zero, bus.rsp_timeout}, {62'd0, vecs[v].dbz, 1'b0});
         step();
      end

      // watchdog: divider never completes
      stub = 1'b1;
      bus.req_dividend[3*W +: W] = 32'd1000;
      bus.req_divisor[3*W +: W]  = 32'd3;
      bus.req_valid = 4'b1000;
      t0 = cyc;
      step();
      bus.req_valid = '0;
      wait_rsp(tr);
      chk("to_latency", 64'(tr - t0), 64'(TO + 2));
      chk("to_flags", {62'd0, bus.rsp_div_by_zero, bus.rsp_timeout}, 64'd1);
      chk("to_q_r", {bus.rsp_quotient, bus.rsp_remainder}, 64'd0);
      step();
      stub  = 1'b0;
      stray = 1'b1;
      step();
      stray = 1'b0;
      bad = 0;
      repeat (5) begin
         if (bus.rsp_valid || bus.div_start) bad++;
         step();
      end
      chk("stray_done_ignored", 64'(bad), 64'd0);

      // response backpressure
      bus.rsp_ready = 1'b0;
      bus.req_dividend[0 +: W] = 32'd50;
      bus.req_divisor[0 +: W]  = 32'd5;
      bus.req_valid = 4'b0001;
      step();
      bus.req_valid = '0;
      wait_rsp(tr);
      sid = int'(bus.rsp_id);
      sq  = bus.rsp_quotient;
      sr  = bus.rsp_remainder;
      sf  = {bus.rsp_div_by_zero, bus.rsp_timeout};
      bus.req_dividend[W +: W] = 32'd81;
      bus.req_divisor[W +: W]  = 32'd9;
      bus.req_valid = 4'b0010;
      bad = 0;
      repeat (10) begin
         step();
         if (!bus.rsp_valid || int'(bus.rsp_id) != sid || bus.rsp_quotient != sq ||
             bus.rsp_remainder != sr || {bus.rsp_div_by_zero, bus.rsp_timeout} != sf ||
             bus.req_ready != '0) bad++;
      end
      chk("hold_stable", 64'(bad), 64'd0);
      chk("hold_q", 64'(sq), 64'd10);
      bus.rsp_ready = 1'b1;
      step();
      chk("bp_next_ready", 64'(bus.req_ready), 64'b0010);
      chk("bp_rsp_dropped", 64'(bus.rsp_valid), 64'd0);
      step();
      bus.req_valid = '0;
      wait_rsp(tr);
      chk("bp_second_id", 64'(bus.rsp_id), 64'd1);
      step();

      // asynchronous reset in WAIT
      bus.req_dividend[2*W +: W] = 32'd1000;
      bus.req_divisor[2*W +: W]  = 32'd10;
      bus.req_valid = 4'b0100;
      step();
      bus.req_valid = '0;
      repeat (5) step();
      chk("pre_rst_in_wait", 64'(bus.div_dividend), 64'd1000);
      rst = 1'b1;
      #1;
      chk("arst_outputs", {bus.rsp_valid, bus.div_start, bus.req_ready, bus.rsp_id,
                           bus.rsp_div_by_zero, bus.rsp_timeout}, 64'd0);
      chk("arst_data", 64'(bus.rsp_quotient | bus.rsp_remainder | bus.div_dividend | bus.div_divisor), 64'd0);
      repeat (2) step();
      rst = 1'b0;
      bus.req_valid = 4'hF;
      #1;
      chk("arst_first_grant", 64'(bus.req_ready), 64'b0001);
      step();
      bus.req_valid = '0;
      wait_rsp(tr);
      chk("arst_rsp_id", 64'(bus.rsp_id), 64'd0);
      step();
      repeat (3) step();

      chk("req_ready_onehot", 64'(onehot_viol), 64'd0);
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
